// File: rtl/instr_mem_loader.sv
// Boot loader: streams a length-prefixed byte image into instruction memory,
// MSB-first 16-bit words from BASE_ADDR, holding the CPU until the load ends.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
// Ports:
//   Clock, Reset (sync, active-high), Start (one-cycle pulse)
//   ByteIn/ByteValid/ByteReady : byte stream handshake
//   ImWrEn/ImWrAddr/ImWrData   : instruction memory write port
//   CpuHold, Done, Error (sticky), WordsLoaded : status
module instr_mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd10,
  parameter int          MAX_WORDS = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        ImWrEn,
  output logic [15:0] ImWrAddr,
  output logic [15:0] ImWrData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordsLoaded
);

  if (int'(BASE_ADDR) + 2 * (MAX_WORDS - 1) > 'hFFFE ||
      MAX_WORDS < 1) begin : g_param_chk
    $error("instr_mem_loader: image would exceed 16-bit address space");
  end

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_ADV,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] n_word;
  logic        xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer   = ByteValid && ByteReady;
  assign n_word = {len_hi, ByteIn};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      ByteReady   <= 1'b0;
      ImWrEn      <= 1'b0;
      ImWrAddr    <= BASE_ADDR;
      ImWrData    <= 16'h0;
      CpuHold     <= 1'b1;
      Done        <= 1'b0;
      Error       <= 1'b0;
      WordsLoaded <= 16'h0;
      len_hi      <= 8'h0;
      len         <= 16'h0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum        <= 8'h0;
`endif
    end else begin
      ImWrEn <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state       <= S_LEN_HI;
            ByteReady   <= 1'b1;
            Done        <= 1'b0;
            CpuHold     <= 1'b1;
            WordsLoaded <= 16'h0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum        <= 8'h0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= ByteIn;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= n_word;
            if (n_word == 16'h0 || n_word > MAX_N) begin
              state     <= S_ERROR;
              ByteReady <= 1'b0;
              Error     <= 1'b1;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            ImWrData[15:8] <= ByteIn;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum           <= csum ^ ByteIn;
`endif
            state          <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            ImWrData[7:0] <= ByteIn;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum          <= csum ^ ByteIn;
`endif
            // strobe is registered here so it is high for the WRITE cycle
            ImWrEn        <= 1'b1;
            ImWrAddr      <= BASE_ADDR + {WordsLoaded[14:0], 1'b0};
            ByteReady     <= 1'b0;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          WordsLoaded <= WordsLoaded + 16'd1;
          state       <= S_ADV;
        end
        S_ADV: begin
          // decide on the already-incremented count
          if (WordsLoaded == len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state     <= S_CHK;
            ByteReady <= 1'b1;
`else
            state     <= S_DONE;
            Done      <= 1'b1;
            CpuHold   <= 1'b0;
`endif
          end else begin
            state     <= S_DATA_HI;
            ByteReady <= 1'b1;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            ByteReady <= 1'b0;
            if (ByteIn == csum) begin
              state   <= S_DONE;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state <= S_ERROR;
              Error <= 1'b1;
            end
          end
        end
`endif
        S_ERROR: begin
          ByteReady <= 1'b0;
          CpuHold   <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          ByteReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frames plus
// randomized frames against a frame-level reference model.
module tb_instr_mem_loader;

  localparam logic [15:0] BASE = 16'd10;
  localparam int          MAXW = 64;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'h0;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        ImWrEn;
  logic [15:0] ImWrAddr;
  logic [15:0] ImWrData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [15:0] WordsLoaded;

  instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .ImWrEn(ImWrEn), .ImWrAddr(ImWrAddr), .ImWrData(ImWrData),
    .CpuHold(CpuHold), .Done(Done), .Error(Error),
    .WordsLoaded(WordsLoaded)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  fr[$];

  always @(negedge Clock)
    if (ImWrEn) wr_q.push_back({ImWrAddr, ImWrData});

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    ByteValid = 1'b0;
    if (gap > 0) tick(gap);
    ByteValid = 1'b1;
    ByteIn = b;
    forever begin
      @(negedge Clock);
      if (ByteReady) break;
      if (++t == 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        ByteValid = 1'b0;
        return;
      end
    end
    @(posedge Clock);
    #1;
    ByteValid = 1'b0;
  endtask

  task automatic send_frame(input int rnd);
    foreach (fr[i])
      send(fr[i], (rnd != 0 && $urandom_range(0, 3) == 0) ?
                  $urandom_range(1, 3) : 0);
  endtask

  task automatic wait_end();
    for (int t = 0; t < 400; t++) begin
      @(negedge Clock);
      if (Done || Error) begin
        @(posedge Clock);
        #1;
        return;
      end
    end
    check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_cnt"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < wr_q.size()) check({tag, "_wr"}, wr_q[i], exp_q[i]);
  endtask

  initial begin
    logic [15:0] n;
    logic [15:0] w;
    logic [7:0]  x;
    logic        valid;
    logic        ok;
    int          kind;

    tick(3);
    Reset = 1'b0;
    check("rst_hold", CpuHold, 1);
    check("rst_done", Done, 0);
    check("rst_err", Error, 0);
    check("rst_rdy", ByteReady, 0);
    check("rst_addr", ImWrAddr, 16'd10);
    check("rst_wen", ImWrEn, 0);
    check("rst_cnt", WordsLoaded, 0);

    // two-word frame, back-to-back
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_frame(0);
    send(8'hCD, 0);
`ifndef INSTR_LOADER_CHECKSUM_EN
    check("lat_wen", ImWrEn, 1);
    check("lat_done_k", Done, 0);
    tick();
    check("lat_done_k1", Done, 0);
    tick();
    check("lat_done_k2", Done, 1);
    check("lat_hold_k2", CpuHold, 0);
`else
    send(8'h40, 0);
    wait_end();
    check("two_done", Done, 1);
`endif
    check("two_cnt", WordsLoaded, 2);
    exp_q = '{32'h000A1234, 32'h000CABCD};
    cmp_writes("two");

    // zero length
    pulse_start();
    fr = '{8'h00, 8'h00};
    send_frame(0);
    tick();
    check("zero_err", Error, 1);
    check("zero_hold", CpuHold, 1);
    check("zero_done", Done, 0);
    pulse_start();
    tick(3);
    check("zero_start_ign", Error, 1);
    check("zero_rdy", ByteReady, 0);
    do_reset();
    check("zero_rst_clr", Error, 0);

    // over-long (65 words)
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h41};
    send_frame(0);
    tick(3);
    check("long_err", Error, 1);
    check("long_nowr", wr_q.size(), 0);
    do_reset();

    // reset during DATA_LO of word 2
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame(0);
    check("mid_rdy", ByteReady, 1);
    Reset = 1'b1;
    ByteValid = 1'b1;
    ByteIn = 8'h44;
    tick();
    Reset = 1'b0;
    ByteValid = 1'b0;
    tick(5);
    exp_q = '{32'h000A1122};
    cmp_writes("mid");
    check("mid_rdy0", ByteReady, 0);
    check("mid_hold", CpuHold, 1);
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h01, 8'h56, 8'h78};
`ifdef INSTR_LOADER_CHECKSUM_EN
    fr.push_back(8'h2E);
`endif
    send_frame(0);
    wait_end();
    check("fresh_done", Done, 1);
    exp_q = '{32'h000A5678};
    cmp_writes("fresh");

`ifdef INSTR_LOADER_CHECKSUM_EN
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    send_frame(0);
    wait_end();
    check("csum_ok", Done, 1);
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    send_frame(0);
    wait_end();
    check("csum_bad", Error, 1);
    exp_q = '{32'h000A1234};
    cmp_writes("csum_bad");
    do_reset();
`endif

    // randomized frames against the frame-level model
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) n = 16'd0;
      else if (kind == 1) n = 16'($urandom_range(65, 300));
      else if (kind == 2) n = 16'(MAXW);
      else n = 16'($urandom_range(1, 6));
      valid = (n != 0) && (n <= 16'(MAXW));
      fr.delete();
      exp_q.delete();
      fr.push_back(n[15:8]);
      fr.push_back(n[7:0]);
      x = 8'h0;
      ok = valid;
      if (valid) begin
        for (int i = 0; i < int'(n); i++) begin
          w = 16'($urandom);
          fr.push_back(w[15:8]);
          fr.push_back(w[7:0]);
          x = x ^ w[15:8] ^ w[7:0];
          exp_q.push_back({16'(BASE + 16'(2 * i)), w});
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) begin
          fr.push_back(x ^ 8'h5A);
          ok = 1'b0;
        end else begin
          fr.push_back(x);
        end
`endif
      end
      wr_q.delete();
      pulse_start();
      send_frame(1);
      wait_end();
      check("rnd_done", Done, ok);
      check("rnd_err", Error, !ok);
      check("rnd_hold", CpuHold, !ok);
      check("rnd_cnt", WordsLoaded, valid ? n : 16'd0);
      cmp_writes("rnd");
      if (!ok) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
